// File: rtl/noc_pkg.sv
// Shared router definitions: port count, target codes, the credit-count type and target checking.
package noc_pkg;

    localparam int NPORT     = 5;
    localparam int TW        = 3;
    localparam int BUF_DEPTH = 4;
    localparam int CW        = 3;

    localparam logic [TW-1:0] TARG_N1 = 3'd1;
    localparam logic [TW-1:0] TARG_N2 = 3'd2;
    localparam logic [TW-1:0] TARG_N3 = 3'd3;
    localparam logic [TW-1:0] TARG_N4 = 3'd4;
    localparam logic [TW-1:0] TARG_N5 = 3'd5;

    typedef logic [CW-1:0] credit_t;
    typedef logic [2:0]    port_idx_t;

    function automatic logic is_valid_targ(input logic [TW-1:0] targ);
        return (targ >= TARG_N1) && (targ <= TARG_N5);
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-request round-robin arbiter: the first asserted request at or after ptr (wrapping) wins.
module rr_arb5
    import noc_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  port_idx_t        ptr,
    output logic [NPORT-1:0] gnt
);

    logic      found;
    int        idx;
    port_idx_t sel;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < NPORT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            sel = port_idx_t'(idx);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_switch_alloc.sv
// Wormhole switch allocator for the 5x5 crossbar with per-output round-robin arbitration.
// Define XSA_CREDIT_EN to replace out_ready with per-output credit counters fed by credit_ret.
module xbar_switch_alloc
    import noc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req_v,
    input  logic [NPORT*TW-1:0] req_targ,
    input  logic [NPORT-1:0]    req_tail,
`ifdef XSA_CREDIT_EN
    input  logic [NPORT-1:0]    credit_ret,
`else
    input  logic [NPORT-1:0]    out_ready,
`endif
    output logic [NPORT-1:0]    cb_ctrl,
    output logic [NPORT-1:0]    out_busy,
    output logic [NPORT-1:0]    err_targ
);

    logic [NPORT-1:0] can_acc;
    logic [NPORT-1:0] lock_q, lock_d;
    logic [NPORT-1:0] err_q, err_d;
    port_idx_t        owner_q [NPORT];
    port_idx_t        owner_d [NPORT];
    port_idx_t        ptr_q   [NPORT];
    port_idx_t        ptr_d   [NPORT];
    logic [NPORT-1:0] arb_req [NPORT];
    logic [NPORT-1:0] arb_gnt [NPORT];
    logic [NPORT-1:0] gnt_all;

`ifdef XSA_CREDIT_EN
    credit_t cred_q [NPORT];
    credit_t cred_d [NPORT];

    always_comb begin
        for (int j = 0; j < NPORT; j++) can_acc[j] = (cred_q[j] != '0);
    end
`else
    assign can_acc = out_ready;
`endif

    // While an output is locked only its owner may compete, so the arbiter simply passes it through.
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            arb_req[j] = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (req_v[i] && (req_targ[i*TW +: TW] == TW'(j + 1)) && can_acc[j] &&
                    (!lock_q[j] || (owner_q[j] == port_idx_t'(i))))
                    arb_req[j][i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_arb
        rr_arb5 u_arb (
            .req (arb_req[g]),
            .ptr (ptr_q[g]),
            .gnt (arb_gnt[g])
        );
    end

    always_comb begin
        gnt_all = '0;
        for (int j = 0; j < NPORT; j++) gnt_all = gnt_all | arb_gnt[j];
    end

    assign cb_ctrl  = rst ? gnt_all : '0;
    assign out_busy = lock_q;
    assign err_targ = err_q;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < NPORT; i++)
            err_d[i] = req_v[i] && !is_valid_targ(req_targ[i*TW +: TW]);
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (arb_gnt[j][i]) begin
                    if (req_tail[i]) begin
                        lock_d[j] = 1'b0;
                        ptr_d[j]  = (i == NPORT - 1) ? '0 : port_idx_t'(i + 1);
                    end else begin
                        lock_d[j]  = 1'b1;
                        owner_d[j] = port_idx_t'(i);
                    end
                end
            end
        end
    end

`ifdef XSA_CREDIT_EN
    // A grant and a return in the same cycle cancel; returns saturate at the buffer depth.
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            cred_d[j] = cred_q[j];
            if ((|arb_gnt[j]) && !credit_ret[j])
                cred_d[j] = cred_q[j] - credit_t'(1);
            else if (!(|arb_gnt[j]) && credit_ret[j] && (cred_q[j] != credit_t'(BUF_DEPTH)))
                cred_d[j] = cred_q[j] + credit_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NPORT; j++) cred_q[j] <= credit_t'(BUF_DEPTH);
        end else begin
            cred_q <= cred_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= '0;
            err_q  <= '0;
            for (int j = 0; j < NPORT; j++) begin
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            lock_q  <= lock_d;
            err_q   <= err_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_xbar_switch_alloc.sv
// Directed bench for xbar_switch_alloc; credit scenarios build when XSA_CREDIT_EN is defined.
module tb_xbar_switch_alloc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  req_v = '0;
    logic [14:0] req_targ = '0;
    logic [4:0]  req_tail = '0;
`ifdef XSA_CREDIT_EN
    logic [4:0]  credit_ret = '0;
`else
    logic [4:0]  out_ready = 5'h1F;
`endif
    logic [4:0]  cb_ctrl;
    logic [4:0]  out_busy;
    logic [4:0]  err_targ;

    int n_assert = 0;
    int n_fail   = 0;

    string      sb_tag_q [$];
    logic [4:0] sb_exp_q [$];

    xbar_switch_alloc dut (
        .clk        (clk),
        .rst        (rst),
        .req_v      (req_v),
        .req_targ   (req_targ),
        .req_tail   (req_tail),
`ifdef XSA_CREDIT_EN
        .credit_ret (credit_ret),
`else
        .out_ready  (out_ready),
`endif
        .cb_ctrl    (cb_ctrl),
        .out_busy   (out_busy),
        .err_targ   (err_targ)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clr();
        req_v    = '0;
        req_targ = '0;
        req_tail = '0;
    endtask

    task automatic put(input int n, input logic [2:0] targ, input logic tail);
        req_v[n-1]          = 1'b1;
        req_targ[(n-1)*3 +: 3] = targ;
        req_tail[n-1]       = tail;
    endtask

    // Inputs are already driven (just after a falling edge); expected grant enters the scoreboard,
    // the combinational output is compared 1 ns later, then time advances to the next falling edge.
    task automatic grant_step(input string tag, input logic [4:0] exp);
        string      t;
        logic [4:0] e;
        sb_tag_q.push_back(tag);
        sb_exp_q.push_back(exp);
        #1;
        t = sb_tag_q.pop_front();
        e = sb_exp_q.pop_front();
        check(t, cb_ctrl, e);
        @(negedge clk);
    endtask

    task automatic idle();
        clr();
`ifdef XSA_CREDIT_EN
        credit_ret = 5'h1F;
        repeat (4) @(negedge clk);
        credit_ret = '0;
`else
        repeat (2) @(negedge clk);
`endif
    endtask

    initial begin
        // Reset with every input requesting
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) put(n, 3'd1, 1'b0);
        @(negedge clk);
        #1;
        check("reset cb_ctrl", cb_ctrl, 5'b00000);
        check("reset out_busy", out_busy, 5'b00000);
        check("reset err_targ", err_targ, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        idle();
        check("post-reset out_busy", out_busy, 5'b00000);

        // Conflict on output 2
        put(1, 3'd2, 1'b1); put(3, 3'd2, 1'b1); put(5, 3'd2, 1'b1);
        grant_step("conflict c1", 5'b00001);
        grant_step("conflict c2", 5'b00100);
        grant_step("conflict c3", 5'b10000);
        grant_step("conflict ptr wrap", 5'b00001);
        idle();

        // Wormhole on output 4
        put(2, 3'd4, 1'b0); put(4, 3'd4, 1'b1);
        grant_step("worm head", 5'b00010);
        check("worm busy after head", out_busy, 5'b01000);
        grant_step("worm body", 5'b00010);
        check("worm busy after body", out_busy, 5'b01000);
        put(2, 3'd4, 1'b1);
        grant_step("worm tail", 5'b00010);
        check("worm busy after tail", out_busy, 5'b00000);
        req_v[1] = 1'b0;
        grant_step("worm waiter", 5'b01000);
        check("worm busy after waiter", out_busy, 5'b00000);
        idle();

        // Owner bubble and downstream stall while locked on output 3
        put(1, 3'd3, 1'b0);
        grant_step("bubble head", 5'b00001);
        req_v[0] = 1'b0;
        put(2, 3'd3, 1'b1);
        grant_step("bubble wait", 5'b00000);
        check("bubble busy held", out_busy, 5'b00100);
`ifndef XSA_CREDIT_EN
        put(1, 3'd3, 1'b0);
        out_ready = 5'b11011;
        grant_step("stall while locked", 5'b00000);
        check("stall busy held", out_busy, 5'b00100);
        out_ready = 5'h1F;
`endif
        put(1, 3'd3, 1'b1);
        grant_step("bubble tail", 5'b00001);
        check("bubble busy released", out_busy, 5'b00000);
        req_v[0] = 1'b0;
        grant_step("bubble next", 5'b00010);
        idle();

        // Fully parallel permutation
        put(1, 3'd5, 1'b1); put(2, 3'd4, 1'b1); put(3, 3'd3, 1'b1);
        put(4, 3'd2, 1'b1); put(5, 3'd1, 1'b1);
        grant_step("parallel", 5'b11111);
        idle();

        // Invalid target codes
        put(3, 3'd7, 1'b1);
        grant_step("invalid 7 no grant", 5'b00000);
        check("err_targ code 7", err_targ, 5'b00100);
        clr();
        put(1, 3'd0, 1'b1); put(5, 3'd6, 1'b1); put(2, 3'd1, 1'b1);
        grant_step("invalid 0/6 mixed", 5'b00010);
        check("err_targ codes 0/6", err_targ, 5'b10001);
        clr();
        grant_step("idle after invalid", 5'b00000);
        check("err_targ pulse ends", err_targ, 5'b00000);
        idle();

        // Reset in the middle of a packet drops the lock
        put(1, 3'd1, 1'b0);
        grant_step("lock before reset", 5'b00001);
        check("busy before reset", out_busy, 5'b00001);
        rst = 1'b0;
        #1;
        check("reset drops lock", out_busy, 5'b00000);
        check("cb_ctrl forced in reset", cb_ctrl, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        clr();
        put(2, 3'd1, 1'b1);
        grant_step("other input after reset", 5'b00010);
        idle();

`ifdef XSA_CREDIT_EN
        // Credit exhaustion, single return, and simultaneous grant/return
        put(1, 3'd1, 1'b1);
        for (int k = 0; k < 4; k++) grant_step($sformatf("credit grant %0d", k), 5'b00001);
        grant_step("credit empty", 5'b00000);
        grant_step("credit still empty", 5'b00000);
        credit_ret = 5'b00001;
        grant_step("return cycle", 5'b00000);
        credit_ret = '0;
        grant_step("one more grant", 5'b00001);
        grant_step("empty again", 5'b00000);
        credit_ret = 5'b00001;
        grant_step("second return", 5'b00000);
        grant_step("grant with return", 5'b00001);
        credit_ret = '0;
        grant_step("count kept", 5'b00001);
        grant_step("empty final", 5'b00000);
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
